// File: rtl/seven_segment_to_decimal.sv
// -----------------------------------------------------------------------------
// seven_segment_to_decimal
//
// Purpose:
//   Recovers a binary number from a two-digit, active-low seven-segment bus.
//   The sampled pattern must be stable for STABLE_CYCLES consecutive matching
//   samples. Once it is, the two glyphs are decoded once. A valid pair reports
//   tens*10+ones with a one-cycle dec_valid strobe. An undecodable pair raises
//   decode_error. A fully blank bus is ignored.
//
// Ports:
//   clk                     in   1  rising-edge system clock
//   reset_n                 in   1  asynchronous active-low reset
//   seven_seg_display_ones  in   7  ones digit, active-low, bit6..0 = g..a
//   seven_seg_display_tens  in   7  tens digit, same encoding
//   dec_number              out  8  last successfully decoded value, 0..99
//   dec_valid               out  1  one-cycle pulse when dec_number updates
//   decode_error            out  1  high while last stable pattern was invalid
// -----------------------------------------------------------------------------
module seven_segment_to_decimal #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] seven_seg_display_ones,
  input  logic [6:0] seven_seg_display_tens,
  output logic [7:0] dec_number,
  output logic       dec_valid,
  output logic       decode_error
);

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [7:0]  LAST_COUNT = 8'(STABLE_CYCLES - 1);
  localparam logic [13:0] ALL_BLANK  = 14'h3FFF;
  localparam logic [6:0]  BLANK      = 7'h7F;

  // Maps one active-low glyph to {valid, value}. Only the ten exact
  // digit shapes are accepted; hex letters and partial glyphs are invalid.
  function automatic logic [4:0] decode_digit(input logic [6:0] seg);
    logic [4:0] result;
    case (seg)
      7'b1000000: result = {1'b1, 4'd0};
      7'b1111001: result = {1'b1, 4'd1};
      7'b0100100: result = {1'b1, 4'd2};
      7'b0110000: result = {1'b1, 4'd3};
      7'b0011001: result = {1'b1, 4'd4};
      7'b0010010: result = {1'b1, 4'd5};
      7'b0000010: result = {1'b1, 4'd6};
      7'b1111000: result = {1'b1, 4'd7};
      7'b0000000: result = {1'b1, 4'd8};
      7'b0010000: result = {1'b1, 4'd9};
      default:    result = {1'b0, 4'd0};
    endcase
    return result;
  endfunction

  logic [13:0] seg_q_r;
  logic [13:0] seg_prev_r;
  state_t      state_r;
  state_t      state_next_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_next_s;
  logic        changed_s;
  logic        report_s;

  logic [4:0]  ones_dec_s;
  logic [4:0]  tens_dec_s;
  logic        tens_blank_s;
  logic        tens_ok_s;
  logic [3:0]  tens_val_s;
  logic [7:0]  value_s;

  logic [7:0]  dec_number_r;
  logic        dec_valid_r;
  logic        decode_error_r;
  logic [7:0]  dec_number_next_s;
  logic        dec_valid_next_s;
  logic        decode_error_next_s;

  // Input sampling stage: current sample and the one before it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q_r    <= ALL_BLANK;
      seg_prev_r <= ALL_BLANK;
    end else begin
      seg_q_r    <= {seven_seg_display_tens, seven_seg_display_ones};
      seg_prev_r <= seg_q_r;
    end
  end

  assign changed_s = (seg_q_r != seg_prev_r);

  // State and stability-counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= SETTLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic: any change restarts settling, regardless of state.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    report_s     = 1'b0;
    if (changed_s) begin
      state_next_s = SETTLE;
      cnt_next_s   = 8'd0;
    end else begin
      case (state_r)
        SETTLE: begin
          if (cnt_r == LAST_COUNT) begin
            report_s     = 1'b1;
            state_next_s = LOCKED;
          end else begin
            cnt_next_s = cnt_r + 8'd1;
          end
        end
        LOCKED: begin
          state_next_s = LOCKED;
        end
        default: begin
          state_next_s = SETTLE;
          cnt_next_s   = 8'd0;
        end
      endcase
    end
  end

  assign ones_dec_s   = decode_digit(seg_q_r[6:0]);
  assign tens_dec_s   = decode_digit(seg_q_r[13:7]);
  assign tens_blank_s = (seg_q_r[13:7] == BLANK);
  // A blank tens digit is leading-zero suppression, so it counts as 0.
  assign tens_ok_s    = tens_dec_s[4] | tens_blank_s;
  assign tens_val_s   = tens_blank_s ? 4'd0 : tens_dec_s[3:0];
  // tens*10 as tens*8 + tens*2; at most 9*10+9 = 99, so 8 bits suffice.
  assign value_s      = ({4'd0, tens_val_s} << 3) + ({4'd0, tens_val_s} << 1)
                      + {4'd0, ones_dec_s[3:0]};

  // Output logic: decide what a report does to the registered outputs.
  always_comb begin
    dec_number_next_s   = dec_number_r;
    dec_valid_next_s    = 1'b0;
    decode_error_next_s = decode_error_r;
    if (report_s) begin
      if (seg_q_r == ALL_BLANK) begin
        // Dark display: nothing to report, outputs hold.
        dec_number_next_s   = dec_number_r;
        decode_error_next_s = decode_error_r;
      end else if (ones_dec_s[4] && tens_ok_s) begin
        dec_number_next_s   = value_s;
        dec_valid_next_s    = 1'b1;
        decode_error_next_s = 1'b0;
      end else begin
        decode_error_next_s = 1'b1;
      end
    end else begin
      dec_valid_next_s = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_number_r   <= 8'd0;
      dec_valid_r    <= 1'b0;
      decode_error_r <= 1'b0;
    end else begin
      dec_number_r   <= dec_number_next_s;
      dec_valid_r    <= dec_valid_next_s;
      decode_error_r <= decode_error_next_s;
    end
  end

  assign dec_number   = dec_number_r;
  assign dec_valid    = dec_valid_r;
  assign decode_error = decode_error_r;

endmodule

// File: tb/tb_seven_segment_to_decimal.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_to_decimal
//
// Purpose:
//   Directed, self-checking bench for seven_segment_to_decimal at the default
//   STABLE_CYCLES = 4. Inputs change 1 time unit after a rising edge. The
//   first edge after that is edge index 0. Outputs are sampled 1 time unit
//   after each edge.
// -----------------------------------------------------------------------------
module tb_seven_segment_to_decimal;

  logic       clk;
  logic       reset_n;
  logic [6:0] ones;
  logic [6:0] tens;
  logic [7:0] dec_number;
  logic       dec_valid;
  logic       decode_error;

  int n_checks;
  int n_fail;
  int back_to_back;
  logic prev_valid;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  logic [6:0] seg_digit [10];

  seven_segment_to_decimal #(.STABLE_CYCLES(4)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .seven_seg_display_ones (ones),
    .seven_seg_display_tens (tens),
    .dec_number             (dec_number),
    .dec_valid              (dec_valid),
    .decode_error           (decode_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags any dec_valid high on two consecutive sampled cycles.
  always @(posedge clk) begin
    #1;
    if (dec_valid && prev_valid) back_to_back = back_to_back + 1;
    prev_valid = dec_valid;
  end

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Applies a pattern and runs for 'cycles' edges (index 0..cycles-1).
  // It reports how many pulses occurred and the first pulse and first error edges.
  task automatic run_pattern(input logic [6:0] t, input logic [6:0] o,
                             input int cycles, output int pulses,
                             output int first_pulse, output int first_err);
    tens = t;
    ones = o;
    pulses = 0;
    first_pulse = -1;
    first_err = -1;
    for (int e = 0; e < cycles; e++) begin
      @(posedge clk);
      #1;
      if (dec_valid) begin
        pulses = pulses + 1;
        if (first_pulse < 0) first_pulse = e;
      end
      if (decode_error && first_err < 0) first_err = e;
    end
  endtask

  int p, fp, fe, total;

  initial begin
    seg_digit[0] = 7'b1000000; seg_digit[1] = 7'b1111001;
    seg_digit[2] = 7'b0100100; seg_digit[3] = 7'b0110000;
    seg_digit[4] = 7'b0011001; seg_digit[5] = 7'b0010010;
    seg_digit[6] = 7'b0000010; seg_digit[7] = 7'b1111000;
    seg_digit[8] = 7'b0000000; seg_digit[9] = 7'b0010000;
    n_checks = 0;
    n_fail = 0;
    back_to_back = 0;
    prev_valid = 1'b0;
    reset_n = 1'b0;
    tens = SEG_BLANK;
    ones = SEG_BLANK;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_number", dec_number, 8'd0);
    check_value("rst_valid", dec_valid, 1'b0);
    check_value("rst_error", decode_error, 1'b0);
    reset_n = 1'b1;

    // Blank bus after reset: silent lock.
    run_pattern(SEG_BLANK, SEG_BLANK, 20, p, fp, fe);
    check_value("blank_pulses", p, 0);
    check_value("blank_error", decode_error, 1'b0);
    check_value("blank_number", dec_number, 8'd0);

    // 25: one pulse after edge 5, none while held.
    run_pattern(seg_digit[2], seg_digit[5], 36, p, fp, fe);
    check_value("d25_pulses", p, 1);
    check_value("d25_edge", fp, 5);
    check_value("d25_number", dec_number, 8'd25);
    check_value("d25_error", decode_error, 1'b0);

    // Leading-zero suppression: blank tens + 6.
    run_pattern(SEG_BLANK, seg_digit[6], 10, p, fp, fe);
    check_value("d06_pulses", p, 1);
    check_value("d06_edge", fp, 5);
    check_value("d06_number", dec_number, 8'd6);

    // Maximum value 99.
    run_pattern(seg_digit[9], seg_digit[9], 10, p, fp, fe);
    check_value("d99_pulses", p, 1);
    check_value("d99_number", dec_number, 8'd99);

    // Glitching ones digit: every 3 cycles, too short to settle.
    total = 0;
    for (int k = 0; k < 5; k++) begin
      run_pattern(seg_digit[0], seg_digit[1], 3, p, fp, fe);
      total = total + p;
      run_pattern(seg_digit[0], seg_digit[2], 3, p, fp, fe);
      total = total + p;
    end
    check_value("toggle_pulses", total, 0);
    check_value("toggle_number", dec_number, 8'd99);
    run_pattern(seg_digit[0], seg_digit[9], 12, p, fp, fe);
    check_value("d09_pulses", p, 1);
    check_value("d09_edge", fp, 5);
    check_value("d09_number", dec_number, 8'd9);

    // Invalid hex glyph: error at edge 5, number held, no pulse.
    run_pattern(seg_digit[2], seg_digit[5], 10, p, fp, fe);
    check_value("d25b_number", dec_number, 8'd25);
    run_pattern(seg_digit[2], SEG_A, 10, p, fp, fe);
    check_value("hexA_pulses", p, 0);
    check_value("hexA_err_edge", fe, 5);
    check_value("hexA_number", dec_number, 8'd25);

    // Fully blank bus leaves the error flag untouched.
    run_pattern(SEG_BLANK, SEG_BLANK, 10, p, fp, fe);
    check_value("blank_keep_pulses", p, 0);
    check_value("blank_keep_error", decode_error, 1'b1);
    check_value("blank_keep_number", dec_number, 8'd25);

    // Valid 42 clears the error.
    run_pattern(seg_digit[4], seg_digit[2], 10, p, fp, fe);
    check_value("d42_pulses", p, 1);
    check_value("d42_number", dec_number, 8'd42);
    check_value("d42_error", decode_error, 1'b0);

    // Blank ones with valid tens is an error.
    run_pattern(seg_digit[1], SEG_BLANK, 10, p, fp, fe);
    check_value("blank_ones_pulses", p, 0);
    check_value("blank_ones_error", decode_error, 1'b1);
    check_value("blank_ones_number", dec_number, 8'd42);

    // Reset between edges 3 and 4 while 37 settles.
    run_pattern(seg_digit[3], seg_digit[7], 4, p, fp, fe);
    check_value("pre_rst_pulses", p, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_value("mid_rst_number", dec_number, 8'd0);
    check_value("mid_rst_error", decode_error, 1'b0);
    check_value("mid_rst_valid", dec_valid, 1'b0);
    total = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (dec_valid) total = total + 1;
    end
    check_value("in_rst_pulses", total, 0);
    reset_n = 1'b1;
    run_pattern(seg_digit[3], seg_digit[7], 12, p, fp, fe);
    check_value("d37_pulses", p, 1);
    check_value("d37_edge", fp + 1, 6);
    check_value("d37_number", dec_number, 8'd37);

    check_value("no_back_to_back", back_to_back, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_to_decimal.md
Name: seven_segment_to_decimal

Overview:
Reverse path of the binary-to-seven-segment display driver. The block samples a two-digit, active-low seven-segment bus, for example a tapped display or an external panel. It waits until the pattern has been stable for a programmable number of cycles, then decodes each digit and reports the binary value 0..99 with a one-cycle valid strobe. Invalid glyphs raise an error flag instead of producing a value. It sits between a segment-bus sampler and any logic that needs the displayed number back as binary.

Parameters:
STABLE_CYCLES, 4, number of consecutive matching samples required before a report; legal range 1..255.

Ports:
clk  input  1  system clock, all logic on the rising edge
reset_n  input  1  asynchronous, active-low reset
seven_seg_display_ones  input  7  ones-digit segments, active-low, bit6..0 = g,f,e,d,c,b,a
seven_seg_display_tens  input  7  tens-digit segments, same encoding
dec_number  output  8  last successfully decoded value, 0..99
dec_valid  output  1  one-cycle pulse when dec_number is updated
decode_error  output  1  level; high while the last stable pattern was not decodable

Behaviour:
- Reset (asynchronous, reset_n low):
  - seg_q and seg_prev (each 14 bits, ones and tens) = 14'h3FFF (all segments off).
  - State = SETTLE, stability counter = 0.
  - dec_number = 8'd0, dec_valid = 0, decode_error = 0.
- Input stage:
  - seg_q <= {tens, ones} every clock.
  - seg_prev <= seg_q every clock.
- States and transitions: SETTLE and LOCKED.
  - Any cycle with seg_q != seg_prev: counter <= 0, state <= SETTLE, no report. This applies in either state.
  - SETTLE with seg_q == seg_prev:
    - If counter == STABLE_CYCLES-1, perform a report and go to LOCKED.
    - Otherwise counter++.
  - LOCKED with seg_q == seg_prev: hold. No further reports until the pattern changes.
- Latency: a pattern applied before edge 0 and held unchanged gives a report at edge STABLE_CYCLES+1 (edge 5 at default). Output effects appear in the following cycle.
- Digit decode (exact match only; any other pattern is invalid):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Hex glyphs A–F (0001000, 0000011, 1000110, 0100001, 0000110, 0001110) are invalid.
- Blank tens (7'h7F) with a valid ones digit means leading-zero suppression; tens is taken as 0.
- Report rules:
  - Both digits valid (after blank substitution): dec_number <= tens*10 + ones, computed in 8 bits, result ≤ 99. dec_valid pulses for 1 cycle, decode_error <= 0.
  - Both digits blank (14'h3FFF): silent. No pulse; dec_number and decode_error are unchanged.
  - Otherwise, including blank ones: decode_error <= 1, dec_number unchanged, no dec_valid pulse.
- dec_valid is never high on two consecutive cycles. A minimum of STABLE_CYCLES+1 cycles separates two pulses.
- Glitch filtering: a change arriving mid-SETTLE restarts the count. Patterns held fewer than STABLE_CYCLES+1 samples never report.
- Reset mid-settle: any pending report is discarded and all outputs return to their reset values immediately (asynchronous).
- Post-reset: bus held blank → lock silently, no error.

Test Plan:
- Release reset with both inputs 7'h7F held for 20 cycles -> dec_valid never high, decode_error 0, dec_number 0.
- tens = 0100100, ones = 0010010 applied before edge 0 and held -> single dec_valid pulse after edge 5, dec_number = 25, decode_error 0. Holding 30 more cycles produces no further pulse.
- tens = 7'h7F, ones = 0000010 held -> dec_number = 6, one dec_valid pulse. Then tens = 0010000, ones = 0010000 -> dec_number = 99.
- ones toggles between 1111001 and 0100100 every 3 cycles for 30 cycles, then holds 0010000 (tens 1000000) -> no pulse during toggling, exactly one pulse with dec_number = 9.
- With dec_number = 25, set ones = 0001000 (A) and hold -> decode_error 1 after edge 5, dec_number stays 25, no dec_valid. Then apply a valid 42 -> decode_error 0, dec_number 42, one pulse.
- Apply 37, pull reset_n low between edges 3 and 4 for 2 cycles, then release with 37 still applied -> outputs zero immediately with no pulse during reset. After release, report 37 at edge STABLE_CYCLES+2 counted from release.
